// File: rtl/display_counter_datapath.sv
// rtl/display_counter_datapath.sv - pixel/line/blank counters, ping-pong buffer addresses and occupancy flags
module display_counter_datapath #(
    parameter int CW        = 10,
    parameter int H_ACTIVE  = 640,
    parameter int H_TOTAL   = 800,
    parameter int V_ACTIVE  = 480,
    parameter int V_TOTAL   = 525,
    parameter int VB_LINES  = 45,
    parameter int BUF_DEPTH = 640
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          IncPx,
    input  logic          ResetPx,
    input  logic          IncLine,
    input  logic          ResetLine,
    input  logic          SyncVB,
    input  logic          IncAddr0,
    input  logic          ResetAddr0,
    input  logic          IncAddr1,
    input  logic          ResetAddr1,
    input  logic          WE0,
    input  logic          RE0,
    input  logic          WE1,
    input  logic          RE1,
    output logic [CW-1:0] Pxout,
    output logic [CW-1:0] Lineout,
    output logic [CW-1:0] VBout,
    output logic [CW-1:0] AIPout,
    output logic [CW-1:0] AILout,
    output logic [CW-1:0] Addr0,
    output logic [CW-1:0] Addr1,
    output logic          AddrWrap0,
    output logic          AddrWrap1,
    output logic          Buf0Empty,
    output logic          Buf1Empty,
    output logic          Buf0Full,
    output logic          Buf1Full,
    output logic          ActiveVideo
);

    localparam int FW = $clog2(BUF_DEPTH + 1);

    localparam logic [CW-1:0] PX_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] LINE_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] VB_LAST   = CW'(VB_LINES - 1);
    localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
    localparam logic [CW-1:0] ADDR_LAST = CW'(BUF_DEPTH - 1);
    localparam logic [FW-1:0] FILL_MAX  = FW'(BUF_DEPTH);

    logic [FW-1:0] fill0, fill1;

    logic [CW-1:0] px_next, line_next, vb_next, aip_next, ail_next;
    logic [CW-1:0] addr0_next, addr1_next;
    logic          wrap0_next, wrap1_next;
    logic [FW-1:0] fill0_next, fill1_next;

    // Next-state for the pixel, line, blank and active-image counters
    always_comb begin
        px_next = Pxout;
        if (ResetPx)
            px_next = '0;
        else if (IncPx)
            px_next = (Pxout == PX_LAST) ? '0 : Pxout + 1'b1;

        line_next = Lineout;
        if (ResetLine)
            line_next = '0;
        else if (IncLine)
            line_next = (Lineout == LINE_LAST) ? '0 : Lineout + 1'b1;

        vb_next = VBout;
        if (!SyncVB)
            vb_next = '0;
        else if (IncLine && (VBout != VB_LAST))
            vb_next = VBout + 1'b1;

        // Active-image indices clamp to the last active position during blanking
        aip_next = (px_next < H_ACT) ? px_next : H_ACT - 1'b1;
        if (SyncVB)
            ail_next = '0;
        else
            ail_next = (line_next < V_ACT) ? line_next : V_ACT - 1'b1;
    end

    // Next-state for both line-buffer address counters and their wrap pulses
    always_comb begin
        addr0_next = Addr0;
        wrap0_next = 1'b0;
        if (ResetAddr0) begin
            addr0_next = '0;
        end else if (IncAddr0) begin
            if (Addr0 == ADDR_LAST) begin
                addr0_next = '0;
                wrap0_next = 1'b1;
            end else begin
                addr0_next = Addr0 + 1'b1;
            end
        end

        addr1_next = Addr1;
        wrap1_next = 1'b0;
        if (ResetAddr1) begin
            addr1_next = '0;
        end else if (IncAddr1) begin
            if (Addr1 == ADDR_LAST) begin
                addr1_next = '0;
                wrap1_next = 1'b1;
            end else begin
                addr1_next = Addr1 + 1'b1;
            end
        end
    end

    // Next-state for the buffer fill levels; simultaneous write+read leaves fill unchanged
    always_comb begin
        fill0_next = fill0;
        unique case ({WE0, RE0})
            2'b10:   if (fill0 != FILL_MAX) fill0_next = fill0 + 1'b1;
            2'b01:   if (fill0 != '0)       fill0_next = fill0 - 1'b1;
            default: fill0_next = fill0;
        endcase

        fill1_next = fill1;
        unique case ({WE1, RE1})
            2'b10:   if (fill1 != FILL_MAX) fill1_next = fill1 + 1'b1;
            2'b01:   if (fill1 != '0)       fill1_next = fill1 - 1'b1;
            default: fill1_next = fill1;
        endcase
    end

    // Register every output; reset overrides all strobes
    always_ff @(posedge clock) begin
        if (reset) begin
            Pxout     <= '0;
            Lineout   <= '0;
            VBout     <= '0;
            AIPout    <= '0;
            AILout    <= '0;
            Addr0     <= '0;
            Addr1     <= '0;
            AddrWrap0 <= 1'b0;
            AddrWrap1 <= 1'b0;
            fill0     <= '0;
            fill1     <= '0;
            Buf0Empty <= 1'b1;
            Buf1Empty <= 1'b1;
            Buf0Full  <= 1'b0;
            Buf1Full  <= 1'b0;
        end else begin
            Pxout     <= px_next;
            Lineout   <= line_next;
            VBout     <= vb_next;
            AIPout    <= aip_next;
            AILout    <= ail_next;
            Addr0     <= addr0_next;
            Addr1     <= addr1_next;
            AddrWrap0 <= wrap0_next;
            AddrWrap1 <= wrap1_next;
            fill0     <= fill0_next;
            fill1     <= fill1_next;
            Buf0Empty <= (fill0_next == '0);
            Buf1Empty <= (fill1_next == '0);
            Buf0Full  <= (fill0_next == FILL_MAX);
            Buf1Full  <= (fill1_next == FILL_MAX);
        end
    end

    // Active window decode straight from the registered counts
    always_comb begin
        ActiveVideo = (Pxout < H_ACT) && (Lineout < V_ACT) && !SyncVB;
    end

endmodule

// File: tb/tb_display_counter_datapath.sv
// tb/tb_display_counter_datapath.sv - scoreboard bench for display_counter_datapath
module tb_display_counter_datapath;

    logic       clock = 1'b0;
    logic       reset;
    logic       IncPx, ResetPx, IncLine, ResetLine, SyncVB;
    logic       IncAddr0, ResetAddr0, IncAddr1, ResetAddr1;
    logic       WE0, RE0, WE1, RE1;
    logic [9:0] Pxout, Lineout, VBout, AIPout, AILout, Addr0, Addr1;
    logic       AddrWrap0, AddrWrap1, Buf0Empty, Buf1Empty, Buf0Full, Buf1Full, ActiveVideo;

    display_counter_datapath dut (
        .clock(clock), .reset(reset),
        .IncPx(IncPx), .ResetPx(ResetPx), .IncLine(IncLine), .ResetLine(ResetLine),
        .SyncVB(SyncVB),
        .IncAddr0(IncAddr0), .ResetAddr0(ResetAddr0), .IncAddr1(IncAddr1), .ResetAddr1(ResetAddr1),
        .WE0(WE0), .RE0(RE0), .WE1(WE1), .RE1(RE1),
        .Pxout(Pxout), .Lineout(Lineout), .VBout(VBout), .AIPout(AIPout), .AILout(AILout),
        .Addr0(Addr0), .Addr1(Addr1), .AddrWrap0(AddrWrap0), .AddrWrap1(AddrWrap1),
        .Buf0Empty(Buf0Empty), .Buf1Empty(Buf1Empty), .Buf0Full(Buf0Full), .Buf1Full(Buf1Full),
        .ActiveVideo(ActiveVideo)
    );

    always #5 clock = ~clock;

    localparam int S_PX = 0, S_LINE = 1, S_VB = 2, S_AIP = 3, S_AIL = 4, S_A0 = 5, S_A1 = 6;
    localparam int S_W0 = 7, S_W1 = 8, S_E0 = 9, S_E1 = 10, S_F0 = 11, S_F1 = 12, S_AV = 13;

    typedef struct {
        string name;
        int    id;
        int    value;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic int get_val(input int id);
        case (id)
            S_PX:    return int'(Pxout);
            S_LINE:  return int'(Lineout);
            S_VB:    return int'(VBout);
            S_AIP:   return int'(AIPout);
            S_AIL:   return int'(AILout);
            S_A0:    return int'(Addr0);
            S_A1:    return int'(Addr1);
            S_W0:    return int'(AddrWrap0);
            S_W1:    return int'(AddrWrap1);
            S_E0:    return int'(Buf0Empty);
            S_E1:    return int'(Buf1Empty);
            S_F0:    return int'(Buf0Full);
            S_F1:    return int'(Buf1Full);
            S_AV:    return int'(ActiveVideo);
            default: return -1;
        endcase
    endfunction

    // Monitor: drain the scoreboard on the falling edge, away from the active edge
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            exp_t e;
            int   act;
            e   = sb.pop_front();
            act = get_val(e.id);
            checks++;
            if (act != e.value) begin
                errors++;
                $display("FAIL %s: got %0d expected %0d", e.name, act, e.value);
            end
        end
    end

    task automatic expect_val(input string name, input int id, input int value);
        sb.push_back('{name, id, value});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sync();
        @(negedge clock);
        #1;
    endtask

    task automatic clear_all();
        IncPx = 0; ResetPx = 0; IncLine = 0; ResetLine = 0; SyncVB = 0;
        IncAddr0 = 0; ResetAddr0 = 0; IncAddr1 = 0; ResetAddr1 = 0;
        WE0 = 0; RE0 = 0; WE1 = 0; RE1 = 0;
    endtask

    task automatic all_strobes_high();
        IncPx = 1; ResetPx = 1; IncLine = 1; ResetLine = 1; SyncVB = 0;
        IncAddr0 = 1; ResetAddr0 = 1; IncAddr1 = 1; ResetAddr1 = 1;
        WE0 = 1; RE0 = 0; WE1 = 1; RE1 = 0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_val({tag, "_px"},   S_PX,   0);
        expect_val({tag, "_line"}, S_LINE, 0);
        expect_val({tag, "_vb"},   S_VB,   0);
        expect_val({tag, "_aip"},  S_AIP,  0);
        expect_val({tag, "_ail"},  S_AIL,  0);
        expect_val({tag, "_a0"},   S_A0,   0);
        expect_val({tag, "_a1"},   S_A1,   0);
        expect_val({tag, "_w0"},   S_W0,   0);
        expect_val({tag, "_w1"},   S_W1,   0);
        expect_val({tag, "_e0"},   S_E0,   1);
        expect_val({tag, "_e1"},   S_E1,   1);
        expect_val({tag, "_f0"},   S_F0,   0);
        expect_val({tag, "_f1"},   S_F1,   0);
        expect_val({tag, "_av"},   S_AV,   1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_all();
        reset = 1;
        all_strobes_high();
        step(); step();
        reset = 0;
        clear_all();
        expect_reset_state("reset");
        sync();

        // Pixel counter wrap and reset priority
        IncPx = 1;
        repeat (799) step();
        expect_val("px_799", S_PX, 799);
        expect_val("aip_hold", S_AIP, 639);
        expect_val("av_hblank", S_AV, 0);
        sync();
        step();
        expect_val("px_wrap", S_PX, 0);
        expect_val("aip_wrap", S_AIP, 0);
        expect_val("av_px0", S_AV, 1);
        sync();
        repeat (5) step();
        expect_val("px_5", S_PX, 5);
        expect_val("aip_5", S_AIP, 5);
        sync();
        ResetPx = 1;
        step();
        expect_val("px_rst_prio", S_PX, 0);
        sync();
        clear_all();

        // Line counter, vertical blank saturation and release
        IncLine = 1;
        repeat (524) step();
        expect_val("line_524", S_LINE, 524);
        expect_val("ail_hold", S_AIL, 479);
        expect_val("av_vblank_line", S_AV, 0);
        expect_val("vb_low", S_VB, 0);
        sync();
        SyncVB = 1;
        step();
        expect_val("line_wrap", S_LINE, 0);
        expect_val("vb_1", S_VB, 1);
        expect_val("ail_forced", S_AIL, 0);
        sync();
        repeat (49) step();
        expect_val("line_49", S_LINE, 49);
        expect_val("vb_sat", S_VB, 44);
        expect_val("ail_vb", S_AIL, 0);
        expect_val("av_syncvb", S_AV, 0);
        sync();
        IncLine = 0;
        SyncVB  = 0;
        step();
        expect_val("vb_clear", S_VB, 0);
        expect_val("ail_release", S_AIL, 49);
        expect_val("av_release", S_AV, 1);
        sync();
        clear_all();

        // Address wrap and reset priority
        IncAddr0 = 1;
        repeat (639) step();
        expect_val("a0_639", S_A0, 639);
        expect_val("w0_pre", S_W0, 0);
        sync();
        step();
        expect_val("a0_wrap", S_A0, 0);
        expect_val("w0_pulse", S_W0, 1);
        sync();
        IncAddr0 = 0;
        step();
        expect_val("w0_drop", S_W0, 0);
        expect_val("a0_hold", S_A0, 0);
        sync();
        IncAddr1 = 1;
        repeat (3) step();
        expect_val("a1_3", S_A1, 3);
        sync();
        ResetAddr1 = 1;
        step();
        expect_val("a1_rst_prio", S_A1, 0);
        expect_val("w1_none", S_W1, 0);
        sync();
        clear_all();
        step();
        expect_val("w1_still0", S_W1, 0);
        sync();

        // Buffer 0 occupancy
        WE0 = 1;
        step();
        expect_val("e0_after1", S_E0, 0);
        expect_val("f0_after1", S_F0, 0);
        sync();
        repeat (639) step();
        expect_val("f0_full", S_F0, 1);
        expect_val("e0_full", S_E0, 0);
        expect_val("e1_untouched", S_E1, 1);
        expect_val("f1_untouched", S_F1, 0);
        sync();
        step();
        expect_val("f0_overwrite", S_F0, 1);
        sync();
        WE0 = 0; RE0 = 1;
        step();
        expect_val("f0_one_read", S_F0, 0);
        sync();
        WE0 = 1; RE0 = 0;
        step();
        expect_val("f0_refull", S_F0, 1);
        sync();
        WE0 = 1; RE0 = 1;
        step();
        expect_val("f0_we_re_full", S_F0, 1);
        sync();
        WE0 = 0; RE0 = 1;
        repeat (639) step();
        expect_val("e0_fill1", S_E0, 0);
        expect_val("f0_fill1", S_F0, 0);
        sync();
        step();
        expect_val("e0_empty", S_E0, 1);
        sync();
        step();
        expect_val("e0_underrun", S_E0, 1);
        sync();
        WE0 = 1; RE0 = 0;
        step();
        expect_val("e0_one_write", S_E0, 0);
        sync();
        WE0 = 0; RE0 = 1;
        step();
        expect_val("e0_back_empty", S_E0, 1);
        sync();
        WE0 = 1; RE0 = 1;
        step();
        expect_val("e0_we_re_empty", S_E0, 1);
        expect_val("e1_end", S_E1, 1);
        sync();
        clear_all();

        // Reset in the middle of activity
        ResetPx = 1; ResetLine = 1;
        step();
        clear_all();
        IncPx = 1;
        repeat (300) step();
        IncPx = 0; IncLine = 1;
        repeat (100) step();
        IncLine = 0; WE0 = 1;
        repeat (17) step();
        WE0 = 0; IncAddr0 = 1;
        repeat (7) step();
        clear_all();
        expect_val("mid_px", S_PX, 300);
        expect_val("mid_aip", S_AIP, 300);
        expect_val("mid_line", S_LINE, 100);
        expect_val("mid_ail", S_AIL, 100);
        expect_val("mid_e0", S_E0, 0);
        expect_val("mid_a0", S_A0, 7);
        expect_val("mid_av", S_AV, 1);
        sync();
        all_strobes_high();
        reset = 1;
        step();
        reset = 0;
        clear_all();
        expect_reset_state("midreset");
        sync();

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
